board_input_reader: RTL and testbench

BOARD_INPUT_READER -- requirements
Module: board_input_reader

---
 rtl/board_input_reader.sv | 112 +++++++++++
 tb/tb_board_input_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_input_reader.sv
// board_input_reader: synchronizes and debounces board SW/KEY, latches key-press events and counts presses behind a 4-register read port.
// Ports: clock, reset (async active-low); SW[9:0], KEY[3:0] raw asynchronous inputs (KEY active-low);
//        rd_req/rd_addr[1:0] single-cycle read strobe and register select; rd_data[31:0]/rd_valid response one cycle later.
// Macro SW_DEBOUNCE_EN: when defined SW is debounced like KEY, otherwise SW is only synchronized.
module board_input_reader #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  input  logic        rd_req,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [9:0]       sw_s1_q, sw_s2_q, sw_db;
  logic [3:0]       key_s1_q, key_s2_q, key_db_q, key_db_d, fall;
  logic [CNT_W-1:0] kcnt_q [4];
  logic [CNT_W-1:0] kcnt_d [4];
  logic [3:0]       evt_q, evt_d, clr;
  logic [15:0]      press_q, press_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q;

  // A bit flips only after its synced value has differed for DEBOUNCE_CYCLES
  // consecutive cycles; any agreeing cycle restarts the count.
  always_comb begin
    key_db_d = key_db_q;
    for (int i = 0; i < 4; i++) begin
      kcnt_d[i] = '0;
      if (key_s2_q[i] != key_db_q[i]) begin
        if (kcnt_q[i] == LAST) key_db_d[i] = key_s2_q[i];
        else kcnt_d[i] = kcnt_q[i] + CNT_W'(1);
      end
    end
  end

`ifdef SW_DEBOUNCE_EN
  logic [9:0]       sw_db_q, sw_db_d;
  logic [CNT_W-1:0] scnt_q [10];
  logic [CNT_W-1:0] scnt_d [10];
  always_comb begin
    sw_db_d = sw_db_q;
    for (int i = 0; i < 10; i++) begin
      scnt_d[i] = '0;
      if (sw_s2_q[i] != sw_db_q[i]) begin
        if (scnt_q[i] == LAST) sw_db_d[i] = sw_s2_q[i];
        else scnt_d[i] = scnt_q[i] + CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_db_q <= '0;
      for (int i = 0; i < 10; i++) scnt_q[i] <= '0;
    end else begin
      sw_db_q <= sw_db_d;
      for (int i = 0; i < 10; i++) scnt_q[i] <= scnt_d[i];
    end
  end
  assign sw_db = sw_db_q;
`else
  assign sw_db = sw_s2_q;
`endif

  // Events come from the debounced next state so a press is registered in the
  // same cycle the debounced bit falls; a concurrent read-clear loses to it.
  always_comb begin
    fall    = key_db_q & ~key_db_d;
    clr     = (rd_req && rd_addr == 2'd2) ? evt_q : 4'b0;
    evt_d   = (evt_q & ~clr) | fall;
    press_d = press_q;
    for (int i = 0; i < 4; i++) press_d = press_d + {15'b0, fall[i]};
    rd_data_d = !rd_req          ? rd_data_q :
                rd_addr == 2'd0  ? {22'b0, sw_db} :
                rd_addr == 2'd1  ? {28'b0, ~key_db_q} :
                rd_addr == 2'd2  ? {28'b0, evt_q} :
                                   {16'b0, press_q};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      key_s1_q   <= 4'hF;
      key_s2_q   <= 4'hF;
      key_db_q   <= 4'hF;
      for (int i = 0; i < 4; i++) kcnt_q[i] <= '0;
      evt_q      <= '0;
      press_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      sw_s1_q    <= SW;
      sw_s2_q    <= sw_s1_q;
      key_s1_q   <= KEY;
      key_s2_q   <= key_s1_q;
      key_db_q   <= key_db_d;
      for (int i = 0; i < 4; i++) kcnt_q[i] <= kcnt_d[i];
      evt_q      <= evt_d;
      press_q    <= press_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_req;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_board_input_reader.sv
// tb_board_input_reader: randomized and directed stimulus with a queue scoreboard against a sample-history model.
module tb_board_input_reader;
  localparam int D  = 4;
  localparam int HK = D + 2;
  logic        clock, reset, rd_req, rd_valid;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  int          total, bad;
  logic [33:0] expq [$];
  logic [3:0]  khist [HK];
  logic [9:0]  shist [HK];
  logic [3:0]  m_key, m_evt, nk, mfall, mclr;
  logic [9:0]  m_sw, ns;
  logic [15:0] m_cnt;
  logic        flip;
  logic [33:0] e;
  logic [31:0] last;
  int          khold [4];

  board_input_reader #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .SW(SW), .KEY(KEY),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Reference model: a debounced bit takes the opposite value once the last D
  // synchronized samples (raw inputs two edges old) all disagree with it.
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_key = 4'hF;
        m_sw  = '0;
        m_evt = '0;
        m_cnt = '0;
        expq.delete();
        for (int k = 0; k < HK; k++) begin
          khist[k] = 4'hF;
          shist[k] = '0;
        end
      end else begin
        mclr = '0;
        if (rd_req) begin
          case (rd_addr)
            2'd0: expq.push_back({rd_addr, 22'b0, m_sw});
            2'd1: expq.push_back({rd_addr, 28'b0, ~m_key});
            2'd2: begin
              expq.push_back({rd_addr, 28'b0, m_evt});
              mclr = m_evt;
            end
            default: expq.push_back({rd_addr, 16'b0, m_cnt});
          endcase
        end
        for (int k = HK - 1; k > 0; k--) begin
          khist[k] = khist[k-1];
          shist[k] = shist[k-1];
        end
        khist[0] = KEY;
        shist[0] = SW;
        for (int b = 0; b < 4; b++) begin
          flip = 1'b1;
          for (int k = 2; k < HK; k++) if (khist[k][b] == m_key[b]) flip = 1'b0;
          nk[b] = m_key[b] ^ flip;
        end
`ifdef SW_DEBOUNCE_EN
        for (int b = 0; b < 10; b++) begin
          flip = 1'b1;
          for (int k = 2; k < HK; k++) if (shist[k][b] == m_sw[b]) flip = 1'b0;
          ns[b] = m_sw[b] ^ flip;
        end
`else
        ns = shist[1];
`endif
        mfall = m_key & ~nk;
        m_evt = (m_evt & ~mclr) | mfall;
        m_cnt = m_cnt + 16'($countones(mfall));
        m_key = nk;
        m_sw  = ns;
      end
    end
  end

  initial begin
    last = '0;
    forever begin
      @(negedge clock);
      total++;
      if (!reset) begin
        if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
          bad++;
          $display("FAIL reset_state: rd_valid=%0b rd_data=%h required 0 and 00000000", rd_valid, rd_data);
        end
        last = '0;
      end else if (rd_valid === 1'b1 && expq.size() > 0) begin
        e = expq.pop_front();
        if (rd_data !== e[31:0]) begin
          bad++;
          $display("FAIL read_a%0d: rd_data=%h required %h", e[33:32], rd_data, e[31:0]);
        end
        last = rd_data;
      end else if (rd_valid === 1'b1) begin
        bad++;
        $display("FAIL spurious_valid: rd_valid=1 required 0");
        last = rd_data;
      end else if (expq.size() > 0) begin
        e = expq.pop_front();
        bad++;
        $display("FAIL missing_valid: rd_valid=%0b required 1 (addr %0d)", rd_valid, e[33:32]);
      end else if (rd_valid !== 1'b0 || rd_data !== last) begin
        bad++;
        $display("FAIL hold_data: rd_valid=%0b rd_data=%h required 0 and %h", rd_valid, rd_data, last);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic do_read(input logic [1:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    tick(1);
    rd_req  = 1'b0;
  endtask

  initial begin
    reset = 0; SW = '0; KEY = 4'hF; rd_req = 0; rd_addr = 0;
    tick(3);
    reset = 1;
    for (int a = 0; a < 4; a++) do_read(2'(a));
    KEY = 4'b1101;
    repeat (8) do_read(2'd3);
    do_read(2'd2);
    do_read(2'd2);
    KEY = 4'hF;
    tick(8);
    KEY = 4'b1110;
    tick(3);
    KEY = 4'hF;
    tick(8);
    do_read(2'd2);
    do_read(2'd3);
    do_read(2'd1);
    KEY = 4'b1011;
    tick(5);
    do_read(2'd2);
    do_read(2'd2);
    KEY = 4'hF;
    tick(8);
    force dut.press_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    tick(1);
    release dut.press_q;
    do_read(2'd3);
    KEY = 4'b0111;
    tick(8);
    do_read(2'd3);
    KEY = 4'hF;
    tick(8);
    KEY = 4'b1100;
    tick(8);
    do_read(2'd3);
    KEY = 4'hF;
    tick(8);
    SW = 10'h2A5;
    repeat (8) do_read(2'd0);
    SW = 10'h2A4;
    do_read(2'd0);
    SW = 10'h2A5;
    repeat (8) do_read(2'd0);
    KEY = 4'b0111;
    tick(8);
    rd_req  = 1'b1;
    rd_addr = 2'd3;
    @(posedge clock);
    #1;
    reset  = 0;
    rd_req = 0;
    #1;
    tick(2);
    reset = 1;
    repeat (9) do_read(2'd3);
    do_read(2'd2);
    do_read(2'd3);
    KEY = 4'hF;
    tick(8);
    for (int b = 0; b < 4; b++) khold[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (khold[b] == 0) begin
          KEY[b]   = ~KEY[b];
          khold[b] = $urandom_range(1, 9);
        end else khold[b]--;
      end
      if ($urandom_range(0, 15) == 0) SW = 10'($urandom);
      rd_req  = $urandom_range(0, 2) != 0;
      rd_addr = 2'($urandom);
      reset   = $urandom_range(0, 799) != 0;
      tick(1);
    end
    rd_req = 0;
    reset  = 1;
    tick(3);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
